// File: rtl/fix_field_drain_ctrl.sv
// Read-side controller for the parser tag/value FIFOs: pops one tag and one value together,
// checks FIX framing (8 opens, 10 closes) and presents the pair on a valid/ready stream.
module fix_field_drain_ctrl #(
  parameter int unsigned TAG_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 256,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   t_empty_i,
  input  logic                   t_full_i,
  input  logic [TAG_WIDTH-1:0]   t_data_i,
  output logic                   t_rd_cs_o,
  output logic                   t_rd_en_o,
  input  logic                   v_empty_i,
  input  logic                   v_full_i,
  input  logic [VALUE_WIDTH-1:0] v_data_i,
  output logic                   v_rd_cs_o,
  output logic                   v_rd_en_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [TAG_WIDTH-1:0]   out_tag_o,
  output logic [VALUE_WIDTH-1:0] out_value_o,
  output logic                   out_sof_o,
  output logic                   out_eof_o,
  output logic [7:0]             out_field_idx_o,
  output logic [CNT_WIDTH-1:0]   msg_count_o,
  output logic                   stall_o,
  output logic                   err_pair_timeout_o,
  output logic                   err_seq_o,
  input  logic                   clr_err_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TAG_WIDTH-1:0] SofTag = TAG_WIDTH'(32'h0000_0038);
  localparam logic [TAG_WIDTH-1:0] EofTag = TAG_WIDTH'(32'h0000_3130);

  typedef enum logic [1:0] {StIdle, StRead, StCapt, StPresent} state_e;

  state_e          state_q;
  logic            rd_q;
  logic            in_msg_q;
  logic [TmoW-1:0] tmo_cnt_q;

  logic       both_avail;
  logic       one_avail;
  logic       cap_sof;
  logic       cap_eof;
  logic [7:0] idx_inc;
  logic       seq_err_set;
  logic       tmo_hit;

  assign t_rd_cs_o = rd_q;
  assign t_rd_en_o = rd_q;
  assign v_rd_cs_o = rd_q;
  assign v_rd_en_o = rd_q;
  assign stall_o   = t_full_i | v_full_i;

  always_comb begin
    both_avail  = !t_empty_i && !v_empty_i;
    one_avail   = t_empty_i ^ v_empty_i;
    cap_sof     = (t_data_i == SofTag);
    cap_eof     = (t_data_i == EofTag);
    idx_inc     = (out_field_idx_o == 8'hff) ? 8'hff : out_field_idx_o + 8'd1;
    // A BeginString inside a message, or any other field outside one, breaks framing.
    seq_err_set = (state_q == StCapt) && (cap_sof ? in_msg_q : !in_msg_q);
    tmo_hit     = (state_q == StIdle) && one_avail && (tmo_cnt_q == TmoW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      rd_q               <= 1'b0;
      in_msg_q           <= 1'b0;
      tmo_cnt_q          <= '0;
      out_valid_o        <= 1'b0;
      out_tag_o          <= '0;
      out_value_o        <= '0;
      out_sof_o          <= 1'b0;
      out_eof_o          <= 1'b0;
      out_field_idx_o    <= '0;
      msg_count_o        <= '0;
      err_pair_timeout_o <= 1'b0;
      err_seq_o          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (both_avail) begin
            state_q <= StRead;
            rd_q    <= 1'b1;
          end
        end
        StRead: begin
          rd_q    <= 1'b0;
          state_q <= StCapt;
        end
        StCapt: begin
          out_tag_o       <= t_data_i;
          out_value_o     <= v_data_i;
          out_sof_o       <= cap_sof;
          out_eof_o       <= cap_eof;
          out_field_idx_o <= cap_sof ? 8'd0 : idx_inc;
          if (cap_sof) in_msg_q <= 1'b1;
          out_valid_o     <= 1'b1;
          state_q         <= StPresent;
        end
        StPresent: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= StIdle;
            if (out_eof_o) begin
              msg_count_o <= msg_count_o + CNT_WIDTH'(1);
              in_msg_q    <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Counts only while one FIFO waits on its partner; saturates once the timeout is reached.
      if ((state_q == StIdle) && one_avail) begin
        if (tmo_cnt_q < TmoW'(TIMEOUT)) tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      end else begin
        tmo_cnt_q <= '0;
      end

      if (tmo_hit)        err_pair_timeout_o <= 1'b1;
      else if (clr_err_i) err_pair_timeout_o <= 1'b0;

      if (seq_err_set)    err_seq_o <= 1'b1;
      else if (clr_err_i) err_seq_o <= 1'b0;
    end
  end

endmodule
